// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states,
// byte-mask constants and the alignment predicate.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Size 2'b11 behaves as a word access everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lo[0];
            default: mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane follows a[1] only, so a misaligned half truncates.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        mask        = MASK_W;
        wdata_lanes = wdata;
        load_data   = rdata;
        case (size)
            SIZE_B: begin
                mask        = MASK_B << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                mask        = MASK_H << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                mask        = MASK_W;
                wdata_lanes = wdata;
                load_data   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit between execute and the data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned ops instead of truncating them.
//
// Handshakes: an op is accepted when i_valid && o_ready; a memory request is
// taken when o_dmem_req && i_dmem_ready, and its fields hold until then;
// i_dmem_valid is honoured only while waiting for read data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_load,
    input  logic              i_mem_wen,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [4:0]        i_rd,
    output logic              o_dmem_req,
    input  logic              i_dmem_ready,
    output logic              o_dmem_wen,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [3:0]        o_dmem_mask,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_valid,
    input  logic [31:0]       i_dmem_rdata,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic [4:0]        o_rd,
    output logic [1:0]        o_state
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              o_misaligned
`endif
);

    lsu_state_e        state_q, state_d;
    logic              is_store_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              req_active;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_data;

    // An op with neither load nor store set is not accepted.
    assign accept = i_valid && (state_q == ST_IDLE) && (i_is_load || i_mem_wen);

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (i_dmem_rdata),
        .mask        (lane_mask),
        .wdata_lanes (lane_wdata),
        .load_data   (load_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misalign_in;

    assign misalign_in = is_misaligned(i_size, i_addr[1:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= misalign_in;
        end
    end

    assign o_misaligned = (state_q == ST_DONE) && misalign_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misalign_in ? ST_DONE : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (i_dmem_ready) begin
                    state_d = is_store_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_dmem_valid) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            is_store_q <= 1'b0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
        end else if (accept) begin
            // Stores report rd=0 and rdata=0; a trapped load keeps rdata=0.
            is_store_q <= i_mem_wen;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            addr_q     <= i_addr;
            wdata_q    <= i_wdata;
            rd_q       <= i_mem_wen ? 5'd0 : i_rd;
            rdata_q    <= '0;
        end else if ((state_q == ST_WAIT) && i_dmem_valid) begin
            rdata_q <= load_data;
        end
    end

    assign req_active   = (state_q == ST_REQ);
    assign o_ready      = (state_q == ST_IDLE);
    assign o_dmem_req   = req_active;
    assign o_dmem_wen   = req_active && is_store_q;
    assign o_dmem_addr  = req_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign o_dmem_mask  = req_active ? lane_mask : 4'b0000;
    assign o_dmem_wdata = (req_active && is_store_q) ? lane_wdata : 32'h0;
    assign o_done       = (state_q == ST_DONE);
    assign o_rdata      = rdata_q;
    assign o_rd         = rd_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and lightly randomised bench for load_store_unit with an
// expected-result queue checked on every completion pulse.
module tb_load_store_unit;

    logic        clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_is_load;
    logic        i_mem_wen;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd;
    logic        o_dmem_req;
    logic        i_dmem_ready;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_valid;
    logic [31:0] i_dmem_rdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [4:0]  o_rd;
    logic [1:0]  o_state;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_rd_q[$];

    load_store_unit #(.ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_is_load    (i_is_load),
        .i_mem_wen    (i_mem_wen),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rd         (i_rd),
        .o_dmem_req   (o_dmem_req),
        .i_dmem_ready (i_dmem_ready),
        .o_dmem_wen   (o_dmem_wen),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_mask  (o_dmem_mask),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_valid (i_dmem_valid),
        .i_dmem_rdata (i_dmem_rdata),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_rd         (o_rd),
        .o_state      (o_state)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .o_misaligned (o_misaligned)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op, service the memory side and compare on o_done.
    task automatic do_op(input string name,
                         input logic ld, input logic wen, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdat, input int stall,
                         input logic exp_req, input logic [31:0] exp_addr,
                         input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                         input int exp_lat, input logic exp_mis,
                         input logic [31:0] exp_rdata, input logic [4:0] exp_rd);
        int cycles;
        int req_cycles;
        logic got_done;
        logic req_seen;
        logic pending;
        logic [31:0] got_rdata;
        logic [31:0] got_rd;
        @(negedge clk);
        i_valid    = 1'b1;
        i_is_load  = ld;
        i_mem_wen  = wen;
        i_size     = sz;
        i_unsigned = uns;
        i_addr     = a;
        i_wdata    = wd;
        i_rd       = rd;
        exp_q.push_back(exp_rdata);
        exp_rd_q.push_back({27'h0, exp_rd});
        check({name, " ready_before_accept"}, {31'h0, o_ready}, 32'h1);
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_is_load = 1'b0;
        i_mem_wen = 1'b0;
        cycles = 0;
        req_cycles = 0;
        got_done = 1'b0;
        req_seen = 1'b0;
        pending = 1'b0;
        while (cycles < 30 && !got_done) begin
            @(negedge clk);
            cycles++;
            i_dmem_valid = 1'b0;
            if (pending) begin
                pending = 1'b0;
                if (ld && !wen) begin
                    i_dmem_valid = 1'b1;
                    i_dmem_rdata = rdat;
                end
            end
            if (o_dmem_req) begin
                req_cycles++;
                if (!req_seen || (req_cycles <= stall + 1 && req_cycles > 1)) begin
                    check({name, " dmem_addr"}, o_dmem_addr, exp_addr);
                    check({name, " dmem_mask"}, {28'h0, o_dmem_mask}, {28'h0, exp_mask});
                    check({name, " dmem_wen"}, {31'h0, o_dmem_wen}, {31'h0, wen});
                    if (wen) check({name, " dmem_wdata"}, o_dmem_wdata, exp_wd);
                    check({name, " ready_busy"}, {31'h0, o_ready}, 32'h0);
                end
                req_seen = 1'b1;
                i_dmem_ready = (req_cycles > stall);
                pending = i_dmem_ready;
            end
            if (o_done) begin
                got_done = 1'b1;
                got_rdata = o_rdata;
                got_rd = {27'h0, o_rd};
                check({name, " latency"}, cycles, exp_lat);
                check({name, " rdata"}, got_rdata, exp_q.pop_front());
                check({name, " rd"}, got_rd, exp_rd_q.pop_front());
                check({name, " ready_in_done"}, {31'h0, o_ready}, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
                check({name, " misaligned"}, {31'h0, o_misaligned}, {31'h0, exp_mis});
`else
                check({name, " misaligned_unused"}, {31'h0, exp_mis}, 32'h0);
`endif
            end
        end
        i_dmem_ready = 1'b0;
        i_dmem_valid = 1'b0;
        if (!got_done) begin
            check({name, " timeout_waiting_done"}, 32'h0, 32'h1);
            exp_q.delete();
            exp_rd_q.delete();
        end
        check({name, " req_issued"}, {31'h0, req_seen}, {31'h0, exp_req});
        @(negedge clk);
        check({name, " done_one_cycle"}, {31'h0, o_done}, 32'h0);
        check({name, " ready_after"}, {31'h0, o_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rdat;
        logic        uns;
        logic [7:0]  b;
        logic [31:0] ev;
        logic        late_done;

        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_is_load    = 1'b0;
        i_mem_wen    = 1'b0;
        i_size       = 2'b00;
        i_unsigned   = 1'b0;
        i_addr       = '0;
        i_wdata      = '0;
        i_rd         = '0;
        i_dmem_ready = 1'b0;
        i_dmem_valid = 1'b0;
        i_dmem_rdata = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst ready", {31'h0, o_ready}, 32'h1);
        check("rst req", {31'h0, o_dmem_req}, 32'h0);
        check("rst done", {31'h0, o_done}, 32'h0);
        check("rst rdata", o_rdata, 32'h0);
        check("rst rd", {27'h0, o_rd}, 32'h0);
        check("rst state", {30'h0, o_state}, 32'h0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // name ld wen sz uns addr wdata rd rdat stall | req addr mask wdata lat mis | rdata rd
        do_op("sw", 0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 5'd3, 32'h0, 0,
              1, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 0, 32'h0, 5'd0);
        do_op("sb", 0, 1, 2'b00, 0, 32'h103, 32'h000000A5, 5'd4, 32'h0, 0,
              1, 32'h100, 4'b1000, 32'hA5A5A5A5, 2, 0, 32'h0, 5'd0);
        do_op("sh", 0, 1, 2'b01, 0, 32'h12, 32'h1234ABCD, 5'd0, 32'h0, 0,
              1, 32'h10, 4'b1100, 32'hABCDABCD, 2, 0, 32'h0, 5'd0);
        do_op("lb", 1, 0, 2'b00, 0, 32'h102, 32'h0, 5'd7, 32'h12F45678, 0,
              1, 32'h100, 4'b0100, 32'h0, 3, 0, 32'hFFFFFFF4, 5'd7);
        do_op("lbu", 1, 0, 2'b00, 1, 32'h102, 32'h0, 5'd7, 32'h12F45678, 0,
              1, 32'h100, 4'b0100, 32'h0, 3, 0, 32'h000000F4, 5'd7);
        do_op("lh_stall", 1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd12, 32'h8001FFFF, 3,
              1, 32'h100, 4'b1100, 32'h0, 6, 0, 32'hFFFF8001, 5'd12);
        do_op("lhu", 1, 0, 2'b01, 1, 32'h200, 32'h0, 5'd31, 32'h12349ABC, 0,
              1, 32'h200, 4'b0011, 32'h0, 3, 0, 32'h00009ABC, 5'd31);
        do_op("lw_size3", 1, 0, 2'b11, 0, 32'h4, 32'h0, 5'd1, 32'h87654321, 1,
              1, 32'h4, 4'b1111, 32'h0, 4, 0, 32'h87654321, 5'd1);
        do_op("both_set_store", 1, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, 5'd9, 32'h0, 0,
              1, 32'h40, 4'b1111, 32'h0BADF00D, 2, 0, 32'h0, 5'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_op("lw_misaligned", 1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd9, 32'hCAFEF00D, 0,
              0, 32'h0, 4'b0000, 32'h0, 1, 1, 32'h0, 5'd9);
        do_op("sh_misaligned", 0, 1, 2'b01, 0, 32'h33, 32'h1111, 5'd2, 32'h0, 0,
              0, 32'h0, 4'b0000, 32'h0, 1, 1, 32'h0, 5'd0);
`else
        do_op("lw_misaligned", 1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd9, 32'hCAFEF00D, 0,
              1, 32'h100, 4'b1111, 32'h0, 3, 0, 32'hCAFEF00D, 5'd9);
        do_op("lh_misaligned", 1, 0, 2'b01, 0, 32'h103, 32'h0, 5'd2, 32'h7FFF0000, 0,
              1, 32'h100, 4'b1100, 32'h0, 3, 0, 32'h00007FFF, 5'd2);
`endif

        // random byte loads against a shift-and-extend model
        for (int k = 0; k < 6; k++) begin
            ra   = 32'h300 + $urandom_range(0, 3);
            rdat = $urandom;
            uns  = 1'($urandom_range(0, 1));
            b    = 8'(rdat >> (8 * ra[1:0]));
            ev   = uns ? {24'h0, b} : {{24{b[7]}}, b};
            do_op("rand_lb", 1, 0, 2'b00, uns, ra, 32'h0, 5'(k + 20), rdat, 0,
                  1, 32'h300, 4'(1 << ra[1:0]), 32'h0, 3, 0, ev, 5'(k + 20));
        end

        // neither load nor store: must not be accepted
        @(negedge clk);
        i_valid = 1'b1;
        i_addr  = 32'h80;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("noop ready", {31'h0, o_ready}, 32'h1);
        check("noop req", {31'h0, o_dmem_req}, 32'h0);

        // reset while waiting for read data, then a late response
        @(negedge clk);
        i_valid   = 1'b1;
        i_is_load = 1'b1;
        i_size    = 2'b10;
        i_addr    = 32'h200;
        i_rd      = 5'd5;
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_is_load = 1'b0;
        @(negedge clk);
        check("rstmid req", {31'h0, o_dmem_req}, 32'h1);
        i_dmem_ready = 1'b1;
        @(negedge clk);
        i_dmem_ready = 1'b0;
        check("rstmid in_wait", {30'h0, o_state}, 32'h2);
        i_rst_n = 1'b0;
        @(negedge clk);
        check("rstmid ready", {31'h0, o_ready}, 32'h1);
        check("rstmid req_low", {31'h0, o_dmem_req}, 32'h0);
        check("rstmid rd", {27'h0, o_rd}, 32'h0);
        i_rst_n = 1'b1;
        i_dmem_valid = 1'b1;
        i_dmem_rdata = 32'hFFFFFFFF;
        late_done = 1'b0;
        @(negedge clk);
        i_dmem_valid = 1'b0;
        late_done = late_done | o_done;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            late_done = late_done | o_done;
        end
        check("late_rsp no_done", {31'h0, late_done}, 32'h0);
        check("late_rsp rdata", o_rdata, 32'h0);
        check("late_rsp ready", {31'h0, o_ready}, 32'h1);

        check("scoreboard empty", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that executes the memory half of RV32I loads and stores (`lb/lh/lw/lbu/lhu/sb/sh/sw`) from decoded controls and an ALU-computed address. It sits between the execute stage and the data-memory port. It converts size/sign controls into word-aligned byte-masked requests over a ready/valid memory handshake, and returns sign- or zero-extended load data with the destination register index.

## Interface
Parameters
- `ADDR_W`, 32: byte-address width.

Ports
- `i_clk`  in  1  clock; all state on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  pipeline presents an op.
- `o_ready`  out  1  unit idle and can accept; accept = `i_valid && o_ready`.
- `i_is_load`  in  1  load op.
- `i_mem_wen`  in  1  store op. Both set: treated as store. Neither set: ignored, no accept.
- `i_size`  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word.
- `i_unsigned`  in  1  funct3[2]: zero-extend loads.
- `i_addr`  in  ADDR_W  byte address.
- `i_wdata`  in  32  rs2 store data, low-aligned.
- `i_rd`  in  5  load destination register.
- `o_dmem_req`  out  1  memory request valid.
- `i_dmem_ready`  in  1  memory accepts request.
- `o_dmem_wen`  out  1  request is a write.
- `o_dmem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `o_dmem_mask`  out  4  byte enables.
- `o_dmem_wdata`  out  32  store data shifted into byte lanes.
- `i_dmem_valid`  in  1  read data valid.
- `i_dmem_rdata`  in  32  read word.
- `o_done`  out  1  one-cycle completion pulse.
- `o_rdata`  out  32  extended load result; 0 for stores.
- `o_rd`  out  5  destination of completed op; 0 for stores.
- `o_misaligned`  out  1  one-cycle misalignment flag. Present only with the macro.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `o_ready`=1. On accept, register op, address, size, sign, data and rd. Go to REQ, or to DONE with `o_misaligned` under the macro if misaligned.
- REQ: `o_dmem_req`=1, all request outputs stable until `i_dmem_ready`. On acceptance a store goes to DONE and a load goes to WAIT.
- WAIT: on `i_dmem_valid`, latch the extracted and extended data, go to DONE. `i_dmem_valid` is ignored in all other states.
- DONE: `o_done`=1 for one cycle, then IDLE.
- Mask: byte → `4'b0001 << a[1:0]`; half → `4'b0011 << {a[1],1'b0}`; word → `4'b1111`.
- Write data: byte replicated to all four lanes; half replicated to both halves; word unchanged.
- Load extraction: select lane by `a[1:0]` (byte) or `a[1]` (half), then extend bit 7/15 unless unsigned.
- Misaligned: half with `a[0]`=1, or word with `a[1:0]`≠0.

## Timing
- Reset: state IDLE, `o_ready`=1, all other outputs 0 including `o_rdata` and `o_rd`.
- Minimum latency with ready/valid asserted at earliest: store accept → `o_done` 2 cycles later; load 3 cycles later.
- Read data may arrive no earlier than the cycle after request acceptance.
- Request is never withdrawn once `o_dmem_req` is raised.
- `o_ready` is 0 in REQ, WAIT and DONE, so there is no back-to-back accept in the DONE cycle.
- Reset asserted mid-operation returns to IDLE immediately. Any in-flight memory response is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned ops issue no memory request, go IDLE→DONE with `o_done`=1 and `o_misaligned`=1 in the same cycle, and return `o_rdata`=0.
- Undefined: `o_misaligned` port absent. Misaligned addresses are handled by truncation: half uses `a[1]`, word uses the aligned word. The access proceeds normally.

## Structure
- Package `lsu_pkg`: size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`), state enum, mask constants.
- Sub-module `lsu_align`: purely combinational mask, write-lane replication, load extraction/extension. Instantiated once, fed from the registered op.

## Test plan
- `sw` at 0x100, data 0xDEADBEEF, ready immediate → addr 0x100, mask 1111, wdata 0xDEADBEEF, `o_done` 2 cycles after accept, `o_rd`=0.
- `sb` at 0x103, data 0x000000A5 → mask 1000, wdata 0xA5A5A5A5, addr 0x100.
- `lb` at 0x102, rdata 0x12F45678 → `o_rdata`=0xFFFFFFF4. `lbu` at the same address → 0x000000F4. `o_rd` echoes `i_rd`=7.
- `lh` at 0x102, rdata 0x8001FFFF → 0xFFFF8001. `i_dmem_ready` held low 3 cycles → request fields stable throughout, `o_ready`=0.
- With the macro, `lw` at 0x101 → no `o_dmem_req`, `o_done` and `o_misaligned` pulse 1 cycle after accept. Without the macro → request at 0x100, mask 1111.
- `i_rst_n` low during WAIT → next cycle `o_ready`=1, `o_dmem_req`=0. A late `i_dmem_valid` produces no `o_done`.
